pwm_compare_deadtime: RTL and testbench

//  Consumer end of the PWM carrier: takes a running carrier count, compares it against a

---
 rtl/pwm_compare_deadtime.sv | 196 +++++++++++++++++++
 tb/tb_pwm_compare_deadtime.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare_deadtime.sv
// rtl/pwm_compare_deadtime.sv - carrier compare with shadowed duty and dead-time gate pair
package PKG_pwm;
  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;
endpackage

module pwm_compare_deadtime
  import PKG_pwm::*;
#(
  parameter int CNT_W = 16,
  parameter int DT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] carrier,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] compare,
  input  logic             load_mode,
  input  logic [DT_W-1:0]  deadtime,
  input  _pwm_onoff        pwm_onoff,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             shadow_load
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L    = 3'd1,
    S_DT_H = 3'd2,
    S_H    = 3'd3,
    S_DT_L = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] compare_act;
  logic             raw;
  logic [DT_W-1:0]  dt_cnt;

  logic enabled;
  logic load_point;
  logic dt_zero;
  logic dt_last;

  assign enabled    = (pwm_onoff == PWM_ON);
  // Carrier extremes are the only glitch-free moments to change the duty.
  assign load_point = (carrier == '0) || (load_mode && (carrier == period));
  assign dt_zero    = (deadtime == '0);
  // The counter holds the remaining low cycles; the edge that sees 1 (or 0) ends the gap.
  assign dt_last    = (dt_cnt <= DT_W'(1));

  // Shadow compare register: tracks freely while off, otherwise only at load points.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare_act <= '0;
      shadow_load <= 1'b0;
    end else if (!enabled) begin
      compare_act <= compare;
      shadow_load <= 1'b0;
    end else if (load_point) begin
      compare_act <= compare;
      shadow_load <= 1'b1;
    end else begin
      shadow_load <= 1'b0;
    end
  end

  // Registered comparator: plain unsigned compare, so 0 and >period saturate naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw <= 1'b0;
    end else begin
      raw <= (carrier < compare_act);
    end
  end

  // Dead-time FSM with gate outputs registered alongside the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      dt_cnt <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else if (!enabled) begin
      state  <= S_IDLE;
      dt_cnt <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dt_zero) begin
            state  <= raw ? S_H : S_L;
            dt_cnt <= '0;
            pwm_h  <= raw;
            pwm_l  <= !raw;
          end else begin
            state  <= raw ? S_DT_H : S_DT_L;
            dt_cnt <= deadtime;
            pwm_h  <= 1'b0;
            pwm_l  <= 1'b0;
          end
        end

        S_L: begin
          if (raw) begin
            pwm_l <= 1'b0;
            if (dt_zero) begin
              state  <= S_H;
              dt_cnt <= '0;
              pwm_h  <= 1'b1;
            end else begin
              state  <= S_DT_H;
              dt_cnt <= deadtime;
              pwm_h  <= 1'b0;
            end
          end else begin
            pwm_h <= 1'b0;
            pwm_l <= 1'b1;
          end
        end

        S_H: begin
          if (!raw) begin
            pwm_h <= 1'b0;
            if (dt_zero) begin
              state  <= S_L;
              dt_cnt <= '0;
              pwm_l  <= 1'b1;
            end else begin
              state  <= S_DT_L;
              dt_cnt <= deadtime;
              pwm_l  <= 1'b0;
            end
          end else begin
            pwm_h <= 1'b1;
            pwm_l <= 1'b0;
          end
        end

        S_DT_H: begin
          pwm_h <= 1'b0;
          pwm_l <= 1'b0;
          if (!raw) begin
            // Abort: head back toward low-side with a full, fresh dead interval.
            if (dt_zero) begin
              state  <= S_L;
              dt_cnt <= '0;
              pwm_l  <= 1'b1;
            end else begin
              state  <= S_DT_L;
              dt_cnt <= deadtime;
            end
          end else if (dt_last) begin
            state  <= S_H;
            dt_cnt <= '0;
            pwm_h  <= 1'b1;
          end else begin
            dt_cnt <= dt_cnt - DT_W'(1);
          end
        end

        S_DT_L: begin
          pwm_h <= 1'b0;
          pwm_l <= 1'b0;
          if (raw) begin
            // Abort: head back toward high-side with a full, fresh dead interval.
            if (dt_zero) begin
              state  <= S_H;
              dt_cnt <= '0;
              pwm_h  <= 1'b1;
            end else begin
              state  <= S_DT_H;
              dt_cnt <= deadtime;
            end
          end else if (dt_last) begin
            state  <= S_L;
            dt_cnt <= '0;
            pwm_l  <= 1'b1;
          end else begin
            dt_cnt <= dt_cnt - DT_W'(1);
          end
        end

        default: begin
          state  <= S_IDLE;
          dt_cnt <= '0;
          pwm_h  <= 1'b0;
          pwm_l  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// tb/tb_pwm_compare_deadtime.sv - scoreboard bench for pwm_compare_deadtime
module tb_pwm_compare_deadtime;
  import PKG_pwm::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] carrier;
  logic [15:0] period;
  logic [15:0] compare;
  logic        load_mode;
  logic [7:0]  deadtime;
  _pwm_onoff   onoff;
  logic        pwm_h;
  logic        pwm_l;
  logic        shadow_load;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic h;
    logic l;
    logic sl;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_cact;
  logic        m_raw;
  logic        hist_en[$];
  logic        hist_s[$];
  int          cmode;
  logic        dir_down;

  pwm_compare_deadtime #(.CNT_W(16), .DT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .carrier    (carrier),
    .period     (period),
    .compare    (compare),
    .load_mode  (load_mode),
    .deadtime   (deadtime),
    .pwm_onoff  (onoff),
    .pwm_h      (pwm_h),
    .pwm_l      (pwm_l),
    .shadow_load(shadow_load)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist_en.delete();
    hist_s.delete();
    exp_q.delete();
    m_cact = '0;
    m_raw  = 1'b0;
  endtask

  // Reference: a gate is on only when the last deadtime+1 edges were all enabled and
  // all saw the comparator agreeing with that gate.
  task automatic model_step();
    exp_t e;
    logic en;
    logic nraw;
    int   d;
    bit   ok_h;
    bit   ok_l;
    en = (onoff == PWM_ON);
    hist_en.push_front(en);
    hist_s.push_front(m_raw);
    if (hist_en.size() > 300) begin
      void'(hist_en.pop_back());
      void'(hist_s.pop_back());
    end
    d = int'(deadtime);
    ok_h = (hist_en.size() > d);
    ok_l = ok_h;
    for (int j = 0; j <= d; j++) begin
      if (j < hist_en.size()) begin
        if (!hist_en[j] || !hist_s[j]) ok_h = 1'b0;
        if (!hist_en[j] || hist_s[j]) ok_l = 1'b0;
      end
    end
    e.h = ok_h;
    e.l = ok_l;
    nraw = (carrier < m_cact);
    if (!en) begin
      m_cact = compare;
      e.sl = 1'b0;
    end else if (carrier == 16'd0 || (load_mode && carrier == period)) begin
      m_cact = compare;
      e.sl = 1'b1;
    end else begin
      e.sl = 1'b0;
    end
    m_raw = nraw;
    exp_q.push_back(e);
  endtask

  task automatic next_carrier();
    case (cmode)
      0: carrier = (carrier >= period) ? 16'd0 : carrier + 16'd1;
      1: begin
        if (!dir_down) begin
          if (carrier >= period) begin
            dir_down = 1'b1;
            carrier = carrier - 16'd1;
          end else begin
            carrier = carrier + 16'd1;
          end
        end else begin
          if (carrier == 16'd0) begin
            dir_down = 1'b0;
            carrier = 16'd1;
          end else begin
            carrier = carrier - 16'd1;
          end
        end
      end
      default: carrier = 16'($urandom % (int'(period) + 3));
    endcase
  endtask

  // Commit the inputs set at this negedge, then advance to the next negedge.
  task automatic tick();
    next_carrier();
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic window(input int n, output int hc, output int lc, output int bc, output int sc);
    hc = 0; lc = 0; bc = 0; sc = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      hc += int'(pwm_h);
      lc += int'(pwm_l);
      bc += int'(!pwm_h && !pwm_l);
      sc += int'(shadow_load);
    end
  endtask

  task automatic wait_carrier(input logic [15:0] target, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (carrier == target) found = 1'b1;
      else tick();
    end
    check(name, int'(found), 1);
  endtask

  // Monitor: every clock edge presents gate outputs; compare them with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      check("gate_overlap", int'(pwm_h & pwm_l), 0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pwm_h", int'(pwm_h), int'(e.h));
        check("pwm_l", int'(pwm_l), int'(e.l));
        check("shadow_load", int'(shadow_load), int'(e.sl));
      end
    end
  end

  initial begin
    int hc, lc, bc, sc;
    reset = 1'b1;
    onoff = PWM_OFF;
    carrier = '0;
    period = 16'd100;
    compare = '0;
    load_mode = 1'b0;
    deadtime = 8'd5;
    cmode = 0;
    dir_down = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_h", int'(pwm_h), 0);
    check("reset_l", int'(pwm_l), 0);
    check("reset_sl", int'(shadow_load), 0);
    reset = 1'b0;
    run(5);

    // Basic duty: period 100, compare 40, deadtime 5.
    compare = 16'd40;
    onoff = PWM_ON;
    run(300);
    window(101, hc, lc, bc, sc);
    check("duty40_h", hc, 35);
    check("duty40_l", lc, 56);
    check("duty40_gap", bc, 10);

    // Mid-period compare change only takes effect at the next carrier zero.
    wait_carrier(16'd19, "wait_c19");
    compare = 16'd70;
    window(101, hc, lc, bc, sc);
    check("midchg_loads", sc, 1);
    run(150);
    window(101, hc, lc, bc, sc);
    check("duty70_h", hc, 65);

    // Up/down carrier with loads at both extremes.
    cmode = 1;
    load_mode = 1'b1;
    compare = 16'd30;
    run(250);
    window(200, hc, lc, bc, sc);
    check("updown_loads", sc, 2);

    // Short high pulse shorter than dead time: high side never turns on.
    cmode = 0;
    load_mode = 1'b0;
    onoff = PWM_OFF;
    run(3);
    deadtime = 8'd10;
    compare = 16'd3;
    onoff = PWM_ON;
    run(250);
    window(101, hc, lc, bc, sc);
    check("abort_h", hc, 0);
    check("abort_l", lc, 88);
    compare = 16'd0;
    run(250);
    window(101, hc, lc, bc, sc);
    check("cmp0_l", lc, 101);
    compare = 16'd101;
    run(250);
    window(101, hc, lc, bc, sc);
    check("cmp101_h", hc, 101);

    // Zero dead time: direct swap, then disable mid-period.
    onoff = PWM_OFF;
    run(3);
    deadtime = 8'd0;
    compare = 16'd50;
    onoff = PWM_ON;
    run(250);
    window(101, hc, lc, bc, sc);
    check("dt0_h", hc, 50);
    check("dt0_l", lc, 51);
    check("dt0_gap", bc, 0);
    wait_carrier(16'd30, "wait_c30");
    onoff = PWM_OFF;
    tick();
    check("off_h", int'(pwm_h), 0);
    check("off_l", int'(pwm_l), 0);

    // Asynchronous reset while the high side is on.
    deadtime = 8'd5;
    compare = 16'd101;
    onoff = PWM_ON;
    run(150);
    check("pre_reset_h", int'(pwm_h), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_h", int'(pwm_h), 0);
    check("async_reset_l", int'(pwm_l), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    onoff = PWM_OFF;
    model_reset();
    run(8);
    onoff = PWM_ON;
    run(200);

    // Randomized phases.
    for (int p = 0; p < 30; p++) begin
      int r;
      onoff = PWM_OFF;
      run(2);
      r = int'($urandom % 10);
      deadtime = (r < 2) ? 8'd0 : (r < 8) ? 8'($urandom % 12) : 8'($urandom % 60);
      r = int'($urandom % 10);
      period = (r < 4) ? 16'($urandom % 19 + 2) : (r < 6) ? 16'd100 : 16'($urandom % 400 + 1);
      cmode = int'($urandom % 3);
      if (($urandom % 8) == 0 && cmode != 1) period = 16'd0;
      load_mode = 1'($urandom % 2);
      compare = 16'($urandom % (int'(period) + 4));
      onoff = PWM_ON;
      r = int'($urandom % 350) + 150;
      for (int i = 0; i < r; i++) begin
        if (($urandom % 20) == 0) compare = 16'($urandom % (int'(period) + 4));
        if (($urandom % 250) == 0) onoff = (onoff == PWM_ON) ? PWM_OFF : PWM_ON;
        tick();
      end
    end

    onoff = PWM_OFF;
    run(3);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
